// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Static branch predictor plus misprediction recovery for the 5-stage
// RISC-V pipeline. Branches are predicted in ID using the rule "backward
// taken, forward not taken", and JAL is always treated as taken. The
// prediction bit travels with the instruction into EX, where the actual
// outcome is compared against it. The block drives the PC redirect and the
// IF/ID and ID/EX flushes, and keeps saturating performance counters.
//
// Ports
//   clk, reset_n         clock (rising edge), async active-low reset
//   BranchD, JumpD       branch / JAL decoded in ID
//   PCD, ImmExtendD      PC and sign-extended immediate of the ID instruction
//   StallD               ID held by the hazard unit
//   FlushEIn             hazard-unit bubble request for ID/EX
//   BranchE, TakenE      branch in EX and its resolved condition
//   PCTargetE, PCPlus4E  taken / fall-through addresses of the EX branch
//   ClearCnt             synchronous clear of both counters
//   PCRedirect           PC mux selects PCRedirectTarget
//   PCRedirectTarget     redirect fetch address (zero when no redirect)
//   FlushD, FlushE       flushes to IF/ID and ID/EX
//   PredTakenE           prediction carried with the EX instruction
//   BranchCnt            branches resolved (saturating)
//   MispredCnt           mispredictions (saturating)

module branch_resolve_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [31:0]      PCD,
  input  logic [31:0]      ImmExtendD,
  input  logic             StallD,
  input  logic             FlushEIn,
  input  logic             BranchE,
  input  logic             TakenE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      PCPlus4E,
  input  logic             ClearCnt,
  output logic             PCRedirect,
  output logic [31:0]      PCRedirectTarget,
  output logic             FlushD,
  output logic             FlushE,
  output logic             PredTakenE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic        pred_taken_d;
  logic        pred_redirect_d;
  logic [31:0] pc_target_d;
  logic        mispredict_e;
  logic [31:0] correct_target_e;

  // A negative immediate means a backward branch, which is predicted taken.
  assign pred_taken_d    = JumpD | (BranchD & ImmExtendD[31]);
  // A stalled ID instruction will be re-evaluated once the stall ends.
  assign pred_redirect_d = pred_taken_d & ~StallD;
  assign pc_target_d     = PCD + ImmExtendD;

  assign mispredict_e     = BranchE & (TakenE ^ PredTakenE);
  assign correct_target_e = TakenE ? PCTargetE : PCPlus4E;

  // EX holds the older instruction, so its correction beats the ID guess.
  always_comb begin
    PCRedirectTarget = 32'b0;
    if (mispredict_e)
      PCRedirectTarget = correct_target_e;
    else if (pred_redirect_d)
      PCRedirectTarget = pc_target_d;
  end

  assign PCRedirect = mispredict_e | pred_redirect_d;
  assign FlushD     = mispredict_e | pred_redirect_d;
  assign FlushE     = mispredict_e | FlushEIn;

  // A stall bubbles EX, so the prediction must not follow the held instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      PredTakenE <= 1'b0;
    else if (FlushE)
      PredTakenE <= 1'b0;
    else if (StallD)
      PredTakenE <= 1'b0;
    else
      PredTakenE <= pred_taken_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else if (ClearCnt) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else begin
      if (BranchE && (BranchCnt != CNT_MAX))
        BranchCnt <= BranchCnt + CNT_ONE;
      if (mispredict_e && (MispredCnt != CNT_MAX))
        MispredCnt <= MispredCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit, built with 4-bit counters so that
// saturation can be reached in a few cycles. Inputs change on the falling
// edge, and outputs are sampled 1 time unit later. Every expected value is
// a hand-computed constant.

module tb_branch_resolve_unit;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             BranchD;
  logic             JumpD;
  logic [31:0]      PCD;
  logic [31:0]      ImmExtendD;
  logic             StallD;
  logic             FlushEIn;
  logic             BranchE;
  logic             TakenE;
  logic [31:0]      PCTargetE;
  logic [31:0]      PCPlus4E;
  logic             ClearCnt;
  logic             PCRedirect;
  logic [31:0]      PCRedirectTarget;
  logic             FlushD;
  logic             FlushE;
  logic             PredTakenE;
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] MispredCnt;

  int vectors;
  int miscompares;

  branch_resolve_unit #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .BranchD          (BranchD),
    .JumpD            (JumpD),
    .PCD              (PCD),
    .ImmExtendD       (ImmExtendD),
    .StallD           (StallD),
    .FlushEIn         (FlushEIn),
    .BranchE          (BranchE),
    .TakenE           (TakenE),
    .PCTargetE        (PCTargetE),
    .PCPlus4E         (PCPlus4E),
    .ClearCnt         (ClearCnt),
    .PCRedirect       (PCRedirect),
    .PCRedirectTarget (PCRedirectTarget),
    .FlushD           (FlushD),
    .FlushE           (FlushE),
    .PredTakenE       (PredTakenE),
    .BranchCnt        (BranchCnt),
    .MispredCnt       (MispredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    BranchD = 0; JumpD = 0; PCD = 0; ImmExtendD = 0; StallD = 0; FlushEIn = 0;
    BranchE = 0; TakenE = 0; PCTargetE = 0; PCPlus4E = 0; ClearCnt = 0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    idle_inputs();

    // Reset state, sampled before the first clock edge.
    #3;
    chk("rst_predtaken", 32'(PredTakenE), 32'd0);
    chk("rst_branchcnt", 32'(BranchCnt), 32'd0);
    chk("rst_mispredcnt", 32'(MispredCnt), 32'd0);
    chk("rst_redirect", 32'(PCRedirect), 32'd0);
    chk("rst_flushd", 32'(FlushD), 32'd0);
    chk("rst_flushe", 32'(FlushE), 32'd0);
    chk("rst_target", PCRedirectTarget, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;

    // Backward branch: predicted taken in ID.
    @(negedge clk);
    BranchD = 1; PCD = 32'h100; ImmExtendD = 32'hFFFF_FFF0;
    #1;
    chk("bwd_redirect", 32'(PCRedirect), 32'd1);
    chk("bwd_target", PCRedirectTarget, 32'h0000_00F0);
    chk("bwd_flushd", 32'(FlushD), 32'd1);
    chk("bwd_flushe", 32'(FlushE), 32'd0);

    // It moves to EX and resolves taken, so the prediction was correct.
    @(negedge clk);
    idle_inputs();
    BranchE = 1; TakenE = 1; PCTargetE = 32'hF0; PCPlus4E = 32'h104;
    #1;
    chk("bwd_predtakene", 32'(PredTakenE), 32'd1);
    chk("bwd_ok_redirect", 32'(PCRedirect), 32'd0);
    chk("bwd_ok_flushe", 32'(FlushE), 32'd0);

    // Forward branch: predicted not-taken, so there is no redirect.
    @(negedge clk);
    idle_inputs();
    #1;
    chk("cnt1_branch", 32'(BranchCnt), 32'd1);
    chk("cnt1_mispred", 32'(MispredCnt), 32'd0);
    BranchD = 1; PCD = 32'h110; ImmExtendD = 32'h10;
    #1;
    chk("fwd_redirect", 32'(PCRedirect), 32'd0);
    chk("fwd_target", PCRedirectTarget, 32'h0);
    chk("fwd_flushd", 32'(FlushD), 32'd0);

    // The forward branch resolves taken, which is a misprediction.
    @(negedge clk);
    idle_inputs();
    BranchE = 1; TakenE = 1; PCTargetE = 32'h120; PCPlus4E = 32'h114;
    #1;
    chk("fwd_predtakene", 32'(PredTakenE), 32'd0);
    chk("fwd_mis_redirect", 32'(PCRedirect), 32'd1);
    chk("fwd_mis_target", PCRedirectTarget, 32'h120);
    chk("fwd_mis_flushd", 32'(FlushD), 32'd1);
    chk("fwd_mis_flushe", 32'(FlushE), 32'd1);

    // Backward branch predicted taken, later resolved not-taken.
    @(negedge clk);
    idle_inputs();
    #1;
    chk("cnt2_branch", 32'(BranchCnt), 32'd2);
    chk("cnt2_mispred", 32'(MispredCnt), 32'd1);
    BranchD = 1; PCD = 32'h100; ImmExtendD = 32'hFFFF_FFF0;
    @(negedge clk);
    idle_inputs();
    BranchE = 1; TakenE = 0; PCTargetE = 32'hF0; PCPlus4E = 32'h104;
    #1;
    chk("bwd_mis_predtakene", 32'(PredTakenE), 32'd1);
    chk("bwd_mis_redirect", 32'(PCRedirect), 32'd1);
    chk("bwd_mis_target", PCRedirectTarget, 32'h104);

    // An EX mispredict and a JAL in ID at the same time: the EX target wins.
    @(negedge clk);
    idle_inputs();
    #1;
    chk("cnt3_branch", 32'(BranchCnt), 32'd3);
    chk("cnt3_mispred", 32'(MispredCnt), 32'd2);
    chk("flush_clears_pred", 32'(PredTakenE), 32'd0);
    BranchE = 1; TakenE = 1; PCTargetE = 32'h200; PCPlus4E = 32'h1F4;
    JumpD = 1; PCD = 32'h300; ImmExtendD = 32'h100;
    #1;
    chk("prio_redirect", 32'(PCRedirect), 32'd1);
    chk("prio_target", PCRedirectTarget, 32'h200);
    chk("prio_flushd", 32'(FlushD), 32'd1);
    chk("prio_flushe", 32'(FlushE), 32'd1);

    // A stalled predicted branch does not redirect.
    @(negedge clk);
    idle_inputs();
    #1;
    chk("prio_predtakene", 32'(PredTakenE), 32'd0);
    chk("cnt4_branch", 32'(BranchCnt), 32'd4);
    chk("cnt4_mispred", 32'(MispredCnt), 32'd3);
    BranchD = 1; PCD = 32'h100; ImmExtendD = 32'hFFFF_FFF0; StallD = 1;
    #1;
    chk("stall_redirect", 32'(PCRedirect), 32'd0);
    chk("stall_flushd", 32'(FlushD), 32'd0);
    chk("stall_target", PCRedirectTarget, 32'h0);

    // When the stall ends, the prediction is taken.
    @(negedge clk);
    StallD = 0;
    #1;
    chk("stall_predtakene", 32'(PredTakenE), 32'd0);
    chk("unstall_redirect", 32'(PCRedirect), 32'd1);
    chk("unstall_target", PCRedirectTarget, 32'h0000_00F0);

    // Asynchronous reset in mid-cycle clears everything with no clock edge.
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pre_rst_predtakene", 32'(PredTakenE), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_predtakene", 32'(PredTakenE), 32'd0);
    chk("async_branchcnt", 32'(BranchCnt), 32'd0);
    chk("async_mispredcnt", 32'(MispredCnt), 32'd0);
    chk("async_redirect", 32'(PCRedirect), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // A hazard-unit bubble flushes ID/EX and drops the prediction.
    @(negedge clk);
    BranchD = 1; PCD = 32'h100; ImmExtendD = 32'hFFFF_FFF0; FlushEIn = 1;
    #1;
    chk("bubble_flushe", 32'(FlushE), 32'd1);
    chk("bubble_redirect", 32'(PCRedirect), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("bubble_predtakene", 32'(PredTakenE), 32'd0);

    // 17 branches where the first is mispredicted: BranchCnt stops at 15.
    BranchE = 1; TakenE = 1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      TakenE = 0;
      if (i == 14) begin
        #1;
        chk("sat_reach15", 32'(BranchCnt), 32'd15);
      end
    end
    #1;
    chk("sat_branchcnt", 32'(BranchCnt), 32'd15);
    chk("sat_mispredcnt", 32'(MispredCnt), 32'd1);

    // Clear overrides an increment on the same edge, including a mispredict.
    ClearCnt = 1; BranchE = 1; TakenE = 1;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("clr_branchcnt", 32'(BranchCnt), 32'd0);
    chk("clr_mispredcnt", 32'(MispredCnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Static branch prediction and misprediction recovery controller for the 5-stage RISC-V pipeline. It makes a backward-taken/forward-not-taken prediction in ID and resolves the branch in EX. It produces the PC redirect and the flush requests that feed the IF/ID and ID/EX pipeline registers. It keeps the predicted-taken bit aligned with the instruction as it moves from ID to EX, and maintains saturating branch and misprediction counters.

## Interface
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- BranchD  in  1  conditional branch decoded in ID
- JumpD  in  1  JAL decoded in ID
- PCD  in  32  PC of the ID instruction
- ImmExtendD  in  32  sign-extended immediate of the ID instruction
- StallD  in  1  ID held by the hazard unit (load-use)
- FlushEIn  in  1  hazard unit bubble request for ID/EX
- BranchE  in  1  branch in EX (already cleared in a bubble)
- TakenE  in  1  branch condition outcome from the ALU in EX
- PCTargetE  in  32  PCE + ImmExtendE from the EX datapath
- PCPlus4E  in  32  PC+4 of the EX instruction
- ClearCnt  in  1  synchronous clear of both counters
- PCRedirect  out  1  PC mux selects PCRedirectTarget this cycle
- PCRedirectTarget  out  32  next fetch address when PCRedirect=1
- FlushD  out  1  flush to the IF/ID register
- FlushE  out  1  flush to the ID/EX register
- PredTakenE  out  1  prediction carried with the EX instruction
- BranchCnt  out  CNT_W  branches resolved
- MispredCnt  out  CNT_W  mispredictions

## Operation
- Prediction in ID (combinational):
  - PredTakenD = JumpD | (BranchD & ImmExtendD[31]).
  - PredRedirectD = PredTakenD & ~StallD.
  - PCTargetD = PCD + ImmExtendD, computed modulo 2^32 with the carry dropped.
- Resolution in EX (combinational): MispredictE = BranchE & (TakenE ^ PredTakenE).
  - Correct target = TakenE ? PCTargetE : PCPlus4E.
- Redirect priority: the EX misprediction wins over the ID prediction, because EX holds the older instruction.
  - PCRedirect = MispredictE | PredRedirectD.
  - PCRedirectTarget = MispredictE ? correct target : PCTargetD.
  - When PCRedirect=0, PCRedirectTarget = 32'b0. It is don't-care, but it is driven to zero.
- FlushD = MispredictE | PredRedirectD.
- FlushE = MispredictE | FlushEIn.
- PredTakenE register:
  - if FlushE then 0;
  - else if StallD then 0, because the hazard unit bubbles EX during a stall;
  - else PredTakenD.
- Counters (registered, saturating at all-ones):
  - BranchCnt increments when BranchE=1.
  - MispredCnt increments when MispredictE=1.
  - ClearCnt=1 forces both counters to 0 and overrides any increment in the same cycle.
- Jumps are resolved fully in ID. They never cause a misprediction and are not counted.
- The block contains no FSM beyond the PredTakenE register and the two counters. All control outputs are combinational from the current inputs and registered state.

## Timing
- Reset (reset_n=0, asynchronous): PredTakenE=0, BranchCnt=0, MispredCnt=0.
  - With all inputs low, the outputs read PCRedirect=0, FlushD=0, FlushE=0, PCRedirectTarget=0.
- Release of reset is synchronous to the first clk edge. Counting starts on that edge.
- Predicted-taken branch: redirect in the same cycle the instruction is in ID (1-cycle penalty, one IF/ID slot flushed).
- Misprediction: redirect in the same cycle the branch is in EX (2-cycle penalty, ID and EX slots flushed).
- PredTakenE is valid one cycle after the instruction leaves ID.
- Counters reflect an event on the clk edge that ends the event cycle.

Boundary cases:
- Mispredict and an ID prediction in the same cycle: the EX target is used, and the younger ID instruction is discarded by FlushD.
- StallD=1 with a predicted branch in ID: no redirect. The prediction is re-evaluated when the stall ends.
- Counter at 2^CNT_W-1 plus an increment: it holds its value. No wrap.
- Reset asserted mid-branch: PredTakenE clears immediately, with no dependence on clk.

## Test plan
- Reset with reset_n=0 mid-cycle -> PredTakenE, BranchCnt and MispredCnt all 0 before the next edge; PCRedirect=0.
- Backward branch: BranchD=1, PCD=0x100, ImmExtendD=0xFFFFFFF0 -> PCRedirect=1, target 0xF0, FlushD=1. Next cycle PredTakenE=1.
- Forward branch predicted not-taken, then resolved with TakenE=1, PCTargetE=0x120 -> PCRedirect=1, target 0x120, FlushD=FlushE=1, MispredCnt and BranchCnt each +1.
- Backward branch predicted taken, then resolved with TakenE=0, PCPlus4E=0x104 -> target 0x104, MispredCnt +1.
- EX mispredict (correct target 0x200) while JumpD=1 in ID with PCD+Imm=0x400 -> PCRedirectTarget=0x200.
- CNT_W=4 with 17 branches, the first mispredicted -> BranchCnt saturates at 15. Then ClearCnt=1 together with BranchE=1 -> both counters 0.
